// File: rtl/serial_loader_pkg.sv
// Shared types and sizing helpers for the serial loader.
// Its frames feed the 3-bit storage register.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        COMMIT
    } state_t;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_WIDTH   = 3;
    localparam int DEFAULT_COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_shift.sv
// MSB-first shift register with load-first and shift enables.
// It also provides a running XOR of the stored bits.
module serial_shift #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_first,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] shift_reg,
    output logic [WIDTH-1:0] shift_next,
    output logic             parity
);

    // A frame start discards any partial frame, so load_first wins over shifting.
    assign shift_next = load_first ? WIDTH'(bit_in)
                                   : ((shift_reg << 1) | WIDTH'(bit_in));
    assign parity     = ^shift_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (load_first || shift_en) begin
            shift_reg <= shift_next;
        end
    end

endmodule

// File: rtl/serial_loader.sv
// Serial-to-parallel front end: framed MSB-first stream in, one word plus a
// write_enable pulse out per good frame. Frames with bad parity are dropped.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_valid,
    input  logic             serial_bit,
    input  logic             frame_start,
    output logic             serial_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             write_enable,
    output logic             parity_error,
    output logic             busy
);

    localparam int             CW         = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic             accept;
    logic             load_first;
    logic             shift_en;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             shift_parity;

    assign serial_ready = (state != COMMIT);
    assign busy         = (state != IDLE);
    assign accept       = serial_valid && serial_ready;
    assign load_first   = accept && frame_start;
    assign shift_en     = accept && !frame_start && (state == SHIFT);

    serial_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .load_first(load_first),
        .shift_en  (shift_en),
        .bit_in    (serial_bit),
        .shift_reg (shift_reg),
        .shift_next(shift_next),
        .parity    (shift_parity)
    );

    // data_out and write_enable are loaded on the edge entering COMMIT, so
    // both are valid for the whole COMMIT cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            data_out     <= '0;
            write_enable <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (state == COMMIT) begin
                state <= IDLE;
            end else if (load_first) begin
                parity_error <= 1'b0;
                count        <= CW'(1);
                if (WIDTH != 1) begin
                    state <= SHIFT;
                end else if (PARITY_EN) begin
                    state <= PARITY;
                end else begin
                    state        <= COMMIT;
                    data_out     <= shift_next;
                    write_enable <= 1'b1;
                end
            end else if (accept) begin
                case (state)
                    SHIFT: begin
                        count <= count + CW'(1);
                        if (count == LAST_COUNT) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                            end else begin
                                state        <= COMMIT;
                                data_out     <= shift_next;
                                write_enable <= 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (shift_parity ^ serial_bit) begin
                            parity_error <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state        <= COMMIT;
                            data_out     <= shift_reg;
                            write_enable <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (WIDTH=3, PARITY_EN=1): table vectors plus
// hand-built stall, reset and back-to-back sequences.
module tb_serial_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_valid;
    logic       serial_bit;
    logic       frame_start;
    logic       serial_ready;
    logic [2:0] data_out;
    logic       write_enable;
    logic       parity_error;
    logic       busy;

    // Packed fields: reset, valid, bit, start | data | we, perr, busy, ready
    typedef struct packed {
        logic       rst_n;
        logic       v;
        logic       b;
        logic       s;
        logic [2:0] data;
        logic       we;
        logic       pe;
        logic       bsy;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;
    int   stepNo = 0;
    int   pulses = 0;
    int   lastPulseStep = -1;
    int   firstPulseStep = -1;

    serial_loader #(
        .WIDTH    (3),
        .PARITY_EN(1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_valid(serial_valid),
        .serial_bit  (serial_bit),
        .frame_start (frame_start),
        .serial_ready(serial_ready),
        .data_out    (data_out),
        .write_enable(write_enable),
        .parity_error(parity_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and samples outputs 1 time unit after the edge.
    task automatic applyStimulus(input logic rst_n, input logic v, input logic b,
                                 input logic s);
        reset        = rst_n;
        serial_valid = v;
        serial_bit   = b;
        frame_start  = s;
        @(posedge clock);
        #1;
        stepNo++;
        if (write_enable) begin
            pulses++;
            lastPulseStep = stepNo;
        end
    endtask

    task automatic sendFrame(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1, bits[i], i == 3);
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: run still active at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bits[8];
        int idx;
        int guard;
        int readyLow;
        int lastBitStep;
        logic rdy;

        reset        = 1'b0;
        serial_valid = 1'b0;
        serial_bit   = 1'b0;
        frame_start  = 1'b0;

        vecs.push_back(11'b0000_000_0001);
        vecs.push_back(11'b0000_000_0001);
        // basic frame 1,0,1 parity 0
        vecs.push_back(11'b1111_000_0011);
        vecs.push_back(11'b1100_000_0011);
        vecs.push_back(11'b1110_000_0011);
        vecs.push_back(11'b1100_101_1010);
        vecs.push_back(11'b1000_101_0001);
        // stray bit without frame_start is discarded
        vecs.push_back(11'b1110_101_0001);
        // bad parity 1,1,0 parity 1
        vecs.push_back(11'b1111_101_0011);
        vecs.push_back(11'b1110_101_0011);
        vecs.push_back(11'b1100_101_0011);
        vecs.push_back(11'b1110_101_0101);
        vecs.push_back(11'b1000_101_0101);
        // resync: 1,1 then restart 0,0,1 parity 1
        vecs.push_back(11'b1111_101_0011);
        vecs.push_back(11'b1110_101_0011);
        vecs.push_back(11'b1101_101_0011);
        vecs.push_back(11'b1100_101_0011);
        vecs.push_back(11'b1110_101_0011);
        vecs.push_back(11'b1110_001_1010);
        vecs.push_back(11'b1000_001_0001);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].v, vecs[i].b, vecs[i].s);
            checkOutput($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].data));
            checkOutput($sformatf("vec%0d write_enable", i), 32'(write_enable), 32'(vecs[i].we));
            checkOutput($sformatf("vec%0d parity_error", i), 32'(parity_error), 32'(vecs[i].pe));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            checkOutput($sformatf("vec%0d serial_ready", i), 32'(serial_ready), 32'(vecs[i].rdy));
        end

        // Stalls: frame 0,1,1 parity 0 with two idle cycles after every bit
        pulses      = 0;
        lastBitStep = -1;
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1, 1'(4'b0110 >> i), i == 3);
            if (i == 0) lastBitStep = stepNo;
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("stall pulses", 32'(pulses), 32'd1);
        checkOutput("stall pulse timing", 32'(lastPulseStep), 32'(lastBitStep));
        checkOutput("stall data_out", 32'(data_out), 32'h3);

        // Reset mid-frame, coinciding with an accepted bit
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("reset data_out", 32'(data_out), 32'h0);
        checkOutput("reset write_enable", 32'(write_enable), 32'h0);
        checkOutput("reset parity_error", 32'(parity_error), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset serial_ready", 32'(serial_ready), 32'h1);
        pulses = 0;
        sendFrame(4'b1111);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post-reset pulses", 32'(pulses), 32'd1);
        checkOutput("post-reset data_out", 32'(data_out), 32'h7);
        checkOutput("post-reset parity_error", 32'(parity_error), 32'h0);

        // Back-to-back: frames 100/p1 and 010/p1 with valid held high
        bits     = '{1, 0, 0, 1, 0, 1, 0, 1};
        idx      = 0;
        guard    = 0;
        readyLow = 0;
        pulses   = 0;
        while (idx < 8 && guard < 30) begin
            rdy = serial_ready;
            applyStimulus(1'b1, 1'b1, 1'(bits[idx]), (idx % 4) == 0);
            if (rdy) idx++;
            if (write_enable && pulses == 1) firstPulseStep = stepNo;
            if (!serial_ready) readyLow++;
            checkOutput($sformatf("b2b ready vs commit step %0d", stepNo),
                        32'(serial_ready), 32'(!write_enable));
            guard++;
        end
        checkOutput("b2b stream consumed", 32'(idx), 32'd8);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b pulses", 32'(pulses), 32'd2);
        checkOutput("b2b pulse spacing", 32'(lastPulseStep - firstPulseStep), 32'd5);
        checkOutput("b2b ready-low cycles", 32'(readyLow), 32'd2);
        checkOutput("b2b data_out", 32'(data_out), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_loader.md
# serial_loader

Serial-to-parallel front end for the 3-bit enable-gated storage register. It accepts a framed, MSB-first bit stream over a valid/ready handshake and optionally checks an even-parity bit. Each good frame produces one parallel word plus a single-cycle write_enable pulse, and the pair connects directly to the register's data and write_enable inputs. Frames that fail parity are dropped and flagged, so the register is never written with a bad value.

## Interface
- WIDTH, 3, data bits per frame (≥1); matches the downstream register width
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clock
- serial_valid  in  1  serial_bit/frame_start are valid this cycle
- serial_bit  in  1  next bit of the stream
- frame_start  in  1  qualifies serial_bit as the first (MSB) data bit of a frame
- serial_ready  out  1  loader can accept a bit this cycle
- data_out  out  WIDTH  last committed word; feeds the register data input
- write_enable  out  1  one-cycle pulse; data_out is new this cycle
- parity_error  out  1  sticky; the last completed frame failed parity
- busy  out  1  a frame is in progress (state ≠ IDLE)

## Operation
- Handshake: a bit is accepted when serial_valid && serial_ready are both high in the same cycle. Without that, nothing advances.
- States:
  - IDLE: serial_ready=1. An accepted bit with frame_start=1 loads the shift register with that bit, sets count=1 and moves to SHIFT. If WIDTH=1, it moves to PARITY or COMMIT instead. Accepted bits with frame_start=0 are discarded.
  - SHIFT: serial_ready=1. Each accepted bit is shifted in from the LSB side, so the first bit ends up as the MSB, and count increments. When count reaches WIDTH, the state moves to PARITY if PARITY_EN=1, else to COMMIT.
  - PARITY: serial_ready=1. An accepted bit p passes the check when XOR(shift_reg) ^ p = 0. On pass, go to COMMIT. On fail, set parity_error=1 and go to IDLE with no write.
  - COMMIT: serial_ready=0. data_out is loaded with shift_reg and write_enable=1 for exactly this cycle; unconditionally returns to IDLE.
- Resync: an accepted bit with frame_start=1 in SHIFT or PARITY abandons the current frame and restarts it exactly as from IDLE. No write and no error result.
- parity_error is cleared when a bit with frame_start=1 is accepted. Otherwise it holds its value.
- data_out changes only in COMMIT and holds its value across failed or aborted frames.
- When PARITY_EN=0, the PARITY state is unreachable and parity_error stays 0.

## Timing
- Reset (reset=0 at a clock edge): state=IDLE, count=0, shift_reg=0, data_out=0, write_enable=0, parity_error=0, busy=0. serial_ready reads 1 from the following cycle.
- Reset takes priority over every other event, including mid-frame, in COMMIT, and when it coincides with an accepted bit. An in-flight frame is lost.
- Latency: if the last bit of a frame (last data bit, or the parity bit) is accepted at edge N, write_enable and the new data_out are high during cycle N..N+1. serial_ready is low during that cycle.
- Back-to-back frames: the earliest next frame_start is accepted at edge N+2. The minimum frame period is WIDTH+PARITY_EN+1 cycles.
- serial_ready, busy and write_enable are decoded from registered state, so there are no combinational paths from inputs to outputs.
- count width is $clog2(WIDTH+1). It never wraps, because it resets to 0 or 1 on every frame start.

## Structure
- Package serial_loader_pkg holds the state enum (IDLE, SHIFT, PARITY, COMMIT) and a localparam for the count width helper.
- One sub-module is natural: serial_shift. It is a WIDTH-bit shift register with load-first and shift enables and a running XOR output. The FSM, count and output registers stay in serial_loader.

## Test plan
- Basic frame (WIDTH=3, PARITY_EN=1): send 1 (frame_start), 0, 1, then parity 0, one bit per cycle. Required: write_enable pulses once on the cycle after the parity bit, data_out=3'b101, parity_error=0.
- Bad parity: send 1, 1, 0, then parity 1. Required: no write_enable pulse, parity_error=1, data_out keeps its previous value (3'b101).
- Stalls: frame 0, 1, 1 with parity 0 and serial_valid low for 2 cycles between every bit. Required: data_out=3'b011 and exactly one write_enable pulse, one cycle after the last accepted bit.
- Resync: after 1, 1, send frame_start with 0, then 0, 1 and parity 1. Required: data_out=3'b001, a single write pulse, and parity_error cleared.
- Reset mid-frame: after 2 bits, drive reset=0 for one edge, then send a full frame 1, 1, 1 with parity 1. Required: all outputs are 0 after reset, then data_out=3'b111 with one pulse.
- Back-to-back: two frames with valid held high. Required: serial_ready is 0 only during each COMMIT cycle, and exactly 2 write_enable pulses occur, 5 cycles apart.
